// File: rtl/rr_arbiter4_pkg.sv
// ---------------------------------------------------------------------------
// rr_arbiter4_pkg
// Shared definitions for the 4-way round-robin arbiter:
//   - requester count and index width
//   - hold counter width (covers MAX_HOLD up to 255)
//   - FSM state encoding (IDLE, GRANT)
//   - onehot4(): index -> one-hot grant vector
// ---------------------------------------------------------------------------
package rr_arbiter4_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int HOLD_W  = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Convert an owner index into its one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] onehot4(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    case (idx)
      2'd0:    vec = 4'b0001;
      2'd1:    vec = 4'b0010;
      2'd2:    vec = 4'b0100;
      2'd3:    vec = 4'b1000;
      default: vec = 4'b0000;
    endcase
    return vec;
  endfunction

endpackage : rr_arbiter4_pkg

// File: rtl/rr_arbiter4_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
// Combinational round-robin winner search. Looks for the first set request
// bit starting at ptr and moving upward, wrapping from 3 back to 0.
//
// Ports:
//   req   in  [3:0]  request lines, bit i = requester i
//   ptr   in  [1:0]  first index to consider
//   found out        at least one request is pending
//   idx   out [1:0]  winning requester index (0 when nothing is pending)
// ---------------------------------------------------------------------------
module rr_pick4
  import rr_arbiter4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [2*NUM_REQ-1:0] dbl_s;
  logic [NUM_REQ-1:0]   rot_s;
  logic [IDX_W-1:0]     off_s;

  // Rotate the request vector so that position ptr lands on bit 0, then take
  // the lowest set bit; the offset added back to ptr wraps naturally in 2 bits.
  always_comb begin
    dbl_s = {req, req} >> ptr;
    rot_s = dbl_s[NUM_REQ-1:0];
    if (rot_s[0]) begin
      off_s = 2'd0;
    end else if (rot_s[1]) begin
      off_s = 2'd1;
    end else if (rot_s[2]) begin
      off_s = 2'd2;
    end else if (rot_s[3]) begin
      off_s = 2'd3;
    end else begin
      off_s = 2'd0;
    end
  end

  // Winner index and presence flag.
  always_comb begin
    found = |req;
    if (found) begin
      idx = ptr + off_s;
    end else begin
      idx = 2'd0;
    end
  end

endmodule : rr_pick4

// File: rtl/rr_arbiter4.sv
// ---------------------------------------------------------------------------
// rr_arbiter4
// Four-requester round-robin arbiter with a hold limit. A two-state FSM
// (IDLE/GRANT) grants one requester at a time, keeps the grant until the
// owner pulses done, drops its request, or has held the grant for MAX_HOLD
// cycles (0 = no limit). After every release there is exactly one IDLE cycle
// and the search pointer advances past the previous owner.
//
// Parameters:
//   MAX_HOLD  max consecutive grant cycles per owner, 0 = unlimited (0..255)
//
// Ports:
//   clk      in        rising-edge clock
//   rst_n    in        asynchronous active-low reset
//   req      in  [3:0] request lines
//   done     in        one-cycle release pulse from the owner
//   a1..a4   in        data from requesters 0..3
//   gnt      out [3:0] one-hot grant (registered)
//   sel      out [1:0] owner index for the data mux (registered)
//   busy     out       high while in GRANT (registered)
//   signal   out       owner's data while busy, else 0 (combinational)
//   timeout  out       one-cycle pulse on a hold-limit release (registered)
// ---------------------------------------------------------------------------
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  input  logic               a1,
  input  logic               a2,
  input  logic               a3,
  input  logic               a4,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   sel,
  output logic               busy,
  output logic               signal,
  output logic               timeout
);

  localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_SAT_C = {HOLD_W{1'b1}};

  state_t               state_r, state_s;
  logic [IDX_W-1:0]     ptr_r, ptr_s;
  logic [HOLD_W-1:0]    hold_r, hold_s;
  logic [NUM_REQ-1:0]   gnt_r, gnt_s;
  logic [IDX_W-1:0]     sel_r, sel_s;
  logic                 busy_r, busy_s;
  logic                 timeout_r, timeout_s;

  logic                 found_s;
  logic [IDX_W-1:0]     idx_s;
  logic                 owner_req_s;
  logic                 hold_hit_s;
  logic                 release_s;

  // Round-robin winner search from the current pointer.
  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr_r),
    .found (found_s),
    .idx   (idx_s)
  );

  // Release conditions for the current owner (sel_r holds the owner index).
  always_comb begin
    owner_req_s = req[sel_r];
    if (MAX_HOLD_C != 8'd0) begin
      hold_hit_s = (hold_r >= MAX_HOLD_C);
    end else begin
      hold_hit_s = 1'b0;
    end
    release_s = done | ~owner_req_s | hold_hit_s;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    hold_s    = hold_r;
    gnt_s     = gnt_r;
    sel_s     = sel_r;
    busy_s    = busy_r;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        // done is meaningless here and is deliberately not looked at.
        if (found_s) begin
          state_s = GRANT;
          gnt_s   = onehot4(idx_s);
          sel_s   = idx_s;
          busy_s  = 1'b1;
          hold_s  = 8'd1;
        end else begin
          // sel keeps its last value so the data path stays stable.
          gnt_s  = 4'b0000;
          busy_s = 1'b0;
        end
      end
      GRANT: begin
        if (release_s) begin
          state_s = IDLE;
          gnt_s   = 4'b0000;
          busy_s  = 1'b0;
          ptr_s   = sel_r + 2'd1;
          hold_s  = 8'd0;
          // Only a pure hold-limit release is reported; done or a dropped
          // request takes precedence and suppresses the pulse.
          timeout_s = hold_hit_s & ~done & owner_req_s;
        end else begin
          // Saturate so an unlimited hold never wraps back to a small count.
          if (hold_r != HOLD_SAT_C) begin
            hold_s = hold_r + 8'd1;
          end else begin
            hold_s = hold_r;
          end
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = 4'b0000;
        busy_s  = 1'b0;
        hold_s  = 8'd0;
      end
    endcase
  end

  // State, pointer, hold counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      ptr_r     <= 2'd0;
      hold_r    <= 8'd0;
      gnt_r     <= 4'b0000;
      sel_r     <= 2'd0;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      hold_r    <= hold_s;
      gnt_r     <= gnt_s;
      sel_r     <= sel_s;
      busy_r    <= busy_s;
      timeout_r <= timeout_s;
    end
  end

  // Shared 4:1 data path, gated by busy so idle cycles present 0.
  always_comb begin
    if (busy_r) begin
      case (sel_r)
        2'd0:    signal = a1;
        2'd1:    signal = a2;
        2'd2:    signal = a3;
        2'd3:    signal = a4;
        default: signal = 1'b0;
      endcase
    end else begin
      signal = 1'b0;
    end
  end

  assign gnt     = gnt_r;
  assign sel     = sel_r;
  assign busy    = busy_r;
  assign timeout = timeout_r;

endmodule : rr_arbiter4

// File: tb/tb_rr_arbiter4.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter4
// Self-checking bench for rr_arbiter4 (MAX_HOLD = 3): a table of directed
// vectors, an asynchronous-reset sequence, then randomized traffic compared
// against a behavioural model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_rr_arbiter4;

  localparam int MH = 3;
  localparam int NV = 28;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic       a1, a2, a3, a4;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy, signal, timeout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rr_arbiter4 #(.MAX_HOLD(MH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .a1      (a1),
    .a2      (a2),
    .a3      (a3),
    .a4      (a4),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .signal  (signal),
    .timeout (timeout)
  );

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] a;     // bit0 = a1 ... bit3 = a4
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       to;
    logic       sig;
  } vec_t;

  vec_t vecs [NV];

  // Behavioural model state
  int         m_owner;   // -1 when nobody owns the bus
  int         m_ptr;
  int         m_held;
  int         m_sel;
  logic       m_to;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic d, input logic [3:0] a);
    req  = r;
    done = d;
    {a4, a3, a2, a1} = a;
  endtask

  task automatic setv(input int i, input logic [3:0] r, input logic d, input logic [3:0] a,
                      input logic [3:0] g, input logic [1:0] s, input logic b,
                      input logic t, input logic sg);
    vecs[i].req = r;  vecs[i].done = d; vecs[i].a = a;
    vecs[i].gnt = g;  vecs[i].sel = s;  vecs[i].busy = b;
    vecs[i].to = t;   vecs[i].sig = sg;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_sel   = 0;
    m_to    = 1'b0;
  endtask

  // One clock edge of the arbitration rules, using the inputs sampled there.
  task automatic model_step(input logic [3:0] r, input logic d);
    bit rel_done, rel_drop, rel_to;
    m_to = 1'b0;
    if (m_owner < 0) begin
      if (r != 4'd0) begin
        for (int k = 0; k < 4; k++) begin
          int i;
          i = (m_ptr + k) % 4;
          if (r[i] && m_owner < 0) m_owner = i;
        end
        m_sel  = m_owner;
        m_held = 1;
      end
    end else begin
      rel_done = d;
      rel_drop = !r[m_owner];
      rel_to   = (MH > 0) && (m_held >= MH);
      if (rel_done || rel_drop || rel_to) begin
        m_to    = rel_to && !rel_done && !rel_drop;
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic check_model(input int cyc, input logic [3:0] a);
    logic [3:0] eg;
    logic       esig;
    eg   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
    esig = (m_owner >= 0) ? a[m_sel] : 1'b0;
    chk($sformatf("rnd%0d gnt", cyc), gnt, eg);
    chk($sformatf("rnd%0d sel", cyc), {2'b00, sel}, 4'(m_sel));
    chk($sformatf("rnd%0d busy", cyc), {3'b000, busy}, {3'b000, (m_owner >= 0)});
    chk($sformatf("rnd%0d timeout", cyc), {3'b000, timeout}, {3'b000, m_to});
    chk($sformatf("rnd%0d signal", cyc), {3'b000, signal}, {3'b000, esig});
  endtask

  initial begin
    logic [3:0] r, av;
    logic       d;

    // Directed vectors: inputs applied before an edge, outputs expected after.
    setv( 0, 4'b1111, 1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
    setv( 1, 4'b1111, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    setv( 2, 4'b1111, 1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1);
    setv( 3, 4'b1111, 1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);
    setv( 4, 4'b1111, 1'b0, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
    setv( 5, 4'b1111, 1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);
    setv( 6, 4'b1111, 1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);
    setv( 7, 4'b1111, 1'b1, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0);
    setv( 8, 4'b1111, 1'b0, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
    setv( 9, 4'b1111, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    setv(10, 4'b0010, 1'b0, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
    setv(11, 4'b0011, 1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);
    setv(12, 4'b0011, 1'b0, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
    setv(13, 4'b0011, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    setv(14, 4'b0010, 1'b0, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
    setv(15, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);
    setv(16, 4'b1111, 1'b0, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
    setv(17, 4'b0100, 1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);
    setv(18, 4'b0100, 1'b0, 4'b1011, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
    setv(19, 4'b0100, 1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
    setv(20, 4'b0100, 1'b0, 4'b1011, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
    setv(21, 4'b0100, 1'b0, 4'b1111, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b0);
    setv(22, 4'b0100, 1'b0, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
    setv(23, 4'b1111, 1'b0, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
    setv(24, 4'b0100, 1'b0, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
    setv(25, 4'b0100, 1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);
    setv(26, 4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);
    setv(27, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);

    // Reset state, with all data lines high to show signal is gated.
    rst_n = 1'b0;
    drive(4'b1111, 1'b0, 4'b1111);
    repeat (2) @(negedge clk);
    chk("rst gnt", gnt, 4'b0000);
    chk("rst sel", {2'b00, sel}, 4'd0);
    chk("rst busy", {3'b000, busy}, 4'd0);
    chk("rst timeout", {3'b000, timeout}, 4'd0);
    chk("rst signal", {3'b000, signal}, 4'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i].req, vecs[i].done, vecs[i].a);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d gnt", i), gnt, vecs[i].gnt);
      chk($sformatf("vec%0d sel", i), {2'b00, sel}, {2'b00, vecs[i].sel});
      chk($sformatf("vec%0d busy", i), {3'b000, busy}, {3'b000, vecs[i].busy});
      chk($sformatf("vec%0d timeout", i), {3'b000, timeout}, {3'b000, vecs[i].to});
      chk($sformatf("vec%0d signal", i), {3'b000, signal}, {3'b000, vecs[i].sig});
    end

    // Asynchronous reset in the middle of a grant to requester 3.
    @(negedge clk);
    drive(4'b1000, 1'b0, 4'b1000);
    @(posedge clk);
    #1;
    chk("ar grant gnt", gnt, 4'b1000);
    chk("ar grant signal", {3'b000, signal}, 4'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar async gnt", gnt, 4'b0000);
    chk("ar async busy", {3'b000, busy}, 4'd0);
    chk("ar async signal", {3'b000, signal}, 4'd0);
    chk("ar async sel", {2'b00, sel}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1000, 1'b0, 4'b0000);
    @(posedge clk);
    #1;
    chk("ar regrant gnt", gnt, 4'b1000);
    chk("ar regrant sel", {2'b00, sel}, 4'd3);
    chk("ar regrant busy", {3'b000, busy}, 4'd1);

    // Randomized traffic against the behavioural model.
    @(negedge clk);
    rst_n = 1'b0;
    drive(4'b0000, 1'b0, 4'b0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) r = 4'b0000;
      if (m_owner >= 0 && $urandom_range(0, 9) < 8) r[m_owner] = 1'b1;
      d  = ($urandom_range(0, 5) == 0);
      av = 4'($urandom_range(0, 15));
      drive(r, d, av);
      @(posedge clk);
      model_step(r, d);
      #1;
      check_model(c, av);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_rr_arbiter4
